piso_serializer: RTL and testbench



---
 rtl/piso_serializer_if.sv | 38 +++
 rtl/piso_serializer.sv | 101 ++++++++++
 tb/tb_piso_serializer.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for the parallel-in/serial-out stage.
// The master side belongs to whoever feeds words and consumes bits; the slave side is the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] data;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             sout;
  logic             sout_valid;
  logic             frame_last;
  logic             busy;

  modport master (
    output data,
    output load_valid,
    output shift_en,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  frame_last,
    input  busy
  );

  modport slave (
    input  data,
    input  load_valid,
    input  shift_en,
    output load_ready,
    output sout,
    output sout_valid,
    output frame_last,
    output busy
  );

endinterface

// File: rtl/piso_serializer.sv
// Serial transmit end of the register chain: takes one WIDTH-bit word per handshake
// and shifts it out one bit per enabled cycle, with back-to-back reload and stall support.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  piso_serializer_if.slave    bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic             last_bit;
  logic             load_ready;
  logic             load_accept;
  logic             sout_bit;

  assign last_bit    = (state_q == SHIFT) && (cnt_q == LAST_IDX);
  assign load_accept = bus.load_valid && load_ready;

  // load_ready deliberately ignores load_valid so upstream can wait on it safely.
  always_comb begin
    load_ready = 1'b0;
    case (state_q)
      IDLE:    load_ready = 1'b1;
      SHIFT:   load_ready = bus.shift_en && (cnt_q == LAST_IDX);
      default: load_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load_accept) begin
          shreg_d = bus.data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_en) begin
          if (cnt_q == LAST_IDX) begin
            if (load_accept) begin
              shreg_d = bus.data;
              cnt_d   = '0;
              state_d = SHIFT;
            end else begin
              shreg_d = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // The bit on sout always sits at the outgoing end of the shift register.
  assign sout_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  assign bus.load_ready = load_ready;
  assign bus.sout       = (state_q == SHIFT) ? sout_bit : 1'b0;
  assign bus.sout_valid = (state_q == SHIFT);
  assign bus.busy       = (state_q == SHIFT);
  assign bus.frame_last = last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed scenarios and randomized traffic on an MSB-first
// and an LSB-first instance, checked against a queue-of-pending-bits reference model.
module tb_piso_serializer;

  logic clk;
  logic rst;

  piso_serializer_if #(.WIDTH(4)) bus_m ();
  piso_serializer_if #(.WIDTH(4)) bus_l ();

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_m.slave)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_l.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  // Model: the bits still owed by the current word, oldest first.
  logic mq[$];

  // Packed as {sout, sout_valid, frame_last, busy, load_ready}.
  function automatic logic [4:0] model_outputs(input logic se);
    logic s, v, fl, lr;
    s  = (mq.size() > 0) ? mq[0] : 1'b0;
    v  = (mq.size() > 0);
    fl = (mq.size() == 1);
    lr = (mq.size() == 0) || (se && (mq.size() == 1));
    return {s, v, fl, v, lr};
  endfunction

  task automatic model_clock(input logic lv, input logic [3:0] d, input logic se, input bit msb);
    logic lr;
    lr = (mq.size() == 0) || (se && (mq.size() == 1));
    if ((mq.size() > 0) && se) void'(mq.pop_front());
    if (lv && lr)
      for (int k = 0; k < 4; k++) mq.push_back(msb ? d[3-k] : d[k]);
  endtask

  task automatic drive(input bit sel, input logic lv, input logic [3:0] d, input logic se);
    if (sel) begin
      bus_m.load_valid = lv;
      bus_m.data       = d;
      bus_m.shift_en   = se;
    end else begin
      bus_l.load_valid = lv;
      bus_l.data       = d;
      bus_l.shift_en   = se;
    end
  endtask

  function automatic logic [4:0] outs(input bit sel);
    if (sel)
      return {bus_m.sout, bus_m.sout_valid, bus_m.frame_last, bus_m.busy, bus_m.load_ready};
    return {bus_l.sout, bus_l.sout_valid, bus_l.frame_last, bus_l.busy, bus_l.load_ready};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    drive(1'b1, 1'b0, 4'h0, 1'b1);
    drive(1'b0, 1'b0, 4'h0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    logic [4:0] exp;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 4'b1010, 1'b1);
    mq.delete();
    for (int c = 0; c < 3; c++) begin
      #1;
      obs = outs(1'b1);
      vectors++;
      if (obs !== 5'b00001) begin
        fails++;
        $display("[TB] FAIL reset_hold cyc %0d: got %b want %b", c, obs, 5'b00001);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      drive(1'b1, (c == 0), 4'b1010, 1'b1);
      #1;
      obs = outs(1'b1);
      exp = model_outputs(1'b1);
      vectors++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL reset_release cyc %0d: got %b want %b", c, obs, exp);
      end
      model_clock((c == 0), 4'b1010, 1'b1, 1'b1);
    end
  endtask

  task automatic test_single_word(input bit sel, input logic [3:0] want_seq);
    logic [4:0] obs;
    logic [4:0] exp;
    logic [3:0] seq;
    do_reset();
    seq = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(sel, (c == 0), 4'b1011, 1'b1);
      #1;
      obs = outs(sel);
      exp = model_outputs(1'b1);
      vectors++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL single_word msb=%0d cyc %0d: got %b want %b", sel, c, obs, exp);
      end
      if (c >= 1 && c <= 4) seq = {seq[2:0], obs[4]};
      model_clock((c == 0), 4'b1011, 1'b1, sel);
    end
    vectors++;
    if (seq !== want_seq) begin
      fails++;
      $display("[TB] FAIL single_word_seq msb=%0d: got %b want %b", sel, seq, want_seq);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] obs;
    logic [4:0] exp;
    logic [7:0] seq;
    logic       all_valid;
    logic       lv;
    logic [3:0] d;
    do_reset();
    seq = '0;
    all_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      lv = (c == 0) || (c == 4);
      d  = (c == 4) ? 4'b0110 : 4'b1011;
      drive(1'b1, lv, d, 1'b1);
      #1;
      obs = outs(1'b1);
      exp = model_outputs(1'b1);
      vectors++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL back_to_back cyc %0d: got %b want %b", c, obs, exp);
      end
      if (c >= 1 && c <= 8) begin
        seq       = {seq[6:0], obs[4]};
        all_valid = all_valid & obs[3];
      end
      model_clock(lv, d, 1'b1, 1'b1);
    end
    vectors++;
    if (seq !== 8'b10110110 || all_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL back_to_back_stream: got %b valid %b want 10110110 valid 1", seq, all_valid);
    end
  endtask

  task automatic test_stall();
    logic [4:0] obs;
    logic [4:0] exp;
    logic       se;
    int         busy_cycles;
    do_reset();
    busy_cycles = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      se = !(c == 2 || c == 3);
      drive(1'b1, (c == 0), 4'b1001, se);
      #1;
      obs = outs(1'b1);
      exp = model_outputs(se);
      vectors++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL stall cyc %0d: got %b want %b", c, obs, exp);
      end
      if (obs[3] === 1'b1) busy_cycles++;
      model_clock((c == 0), 4'b1001, se, 1'b1);
    end
    vectors++;
    if (busy_cycles != 6) begin
      fails++;
      $display("[TB] FAIL stall_length: got %0d cycles want 6", busy_cycles);
    end
  endtask

  task automatic test_busy_ignore();
    logic [4:0] obs;
    logic [4:0] exp;
    logic [7:0] seq;
    logic       lv;
    logic [3:0] d;
    do_reset();
    seq = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      lv = (c <= 4);
      d  = (c == 0) ? 4'b0000 : 4'b1111;
      drive(1'b1, lv, d, 1'b1);
      #1;
      obs = outs(1'b1);
      exp = model_outputs(1'b1);
      vectors++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL busy_ignore cyc %0d: got %b want %b", c, obs, exp);
      end
      if (c >= 1 && c <= 8) seq = {seq[6:0], obs[4]};
      model_clock(lv, d, 1'b1, 1'b1);
    end
    vectors++;
    if (seq !== 8'b00001111) begin
      fails++;
      $display("[TB] FAIL busy_ignore_stream: got %b want 00001111", seq);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs;
    logic [4:0] exp;
    logic [3:0] seq;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b1, (c == 0), 4'b1101, 1'b1);
      #1;
      obs = outs(1'b1);
      exp = model_outputs(1'b1);
      vectors++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL reset_mid_pre cyc %0d: got %b want %b", c, obs, exp);
      end
      model_clock((c == 0), 4'b1101, 1'b1, 1'b1);
    end
    @(posedge clk);
    #2;
    obs = outs(1'b1);
    exp = model_outputs(1'b1);
    vectors++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL reset_mid_bit2: got %b want %b", obs, exp);
    end
    rst = 1'b1;
    #1;
    obs = outs(1'b1);
    mq.delete();
    vectors++;
    if (obs !== 5'b00001) begin
      fails++;
      $display("[TB] FAIL reset_mid_async: got %b want %b", obs, 5'b00001);
    end
    @(negedge clk);
    rst = 1'b0;
    seq = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(1'b1, (c == 0), 4'b0011, 1'b1);
      #1;
      obs = outs(1'b1);
      exp = model_outputs(1'b1);
      vectors++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL reset_mid_after cyc %0d: got %b want %b", c, obs, exp);
      end
      if (c >= 1 && c <= 4) seq = {seq[2:0], obs[4]};
      model_clock((c == 0), 4'b0011, 1'b1, 1'b1);
    end
    vectors++;
    if (seq !== 4'b0011) begin
      fails++;
      $display("[TB] FAIL reset_mid_new_word: got %b want 0011", seq);
    end
  endtask

  task automatic test_random(input bit sel);
    logic [4:0] obs;
    logic [4:0] exp;
    logic       lv;
    logic       se;
    logic [3:0] d;
    do_reset();
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      lv = ($urandom_range(0, 2) != 0);
      se = ($urandom_range(0, 3) != 0);
      d  = 4'($urandom);
      drive(sel, lv, d, se);
      #1;
      obs = outs(sel);
      exp = model_outputs(se);
      vectors++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL random msb=%0d cyc %0d: got %b want %b", sel, c, obs, exp);
      end
      model_clock(lv, d, se, sel);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'h0, 1'b1);
    drive(1'b0, 1'b0, 4'h0, 1'b1);
    test_reset();
    test_single_word(1'b1, 4'b1011);
    test_single_word(1'b0, 4'b1101);
    test_back_to_back();
    test_stall();
    test_busy_ignore();
    test_reset_mid();
    test_random(1'b1);
    test_random(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
